f1_start_ctrl: RTL and testbench
================================

Name: f1_start_ctrl

Overview:
Race-start sequencer for the F1 light strip. A trigger rising edge lights the 8 lamps one at a time on a divided tick, holds all lamps for a pseudo-random number of ticks, then switches them off. It then measures the driver's reaction time in clock cycles. A button press before lights-out is flagged as a jump start.

Parameters:
TICK_DIV, 4, clock cycles per tick (>=2); boards use 24_000_000
CNT_W, 16, width of reaction counter (saturating)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
trigger  input  1  start request; rising edge starts a race
react  input  1  driver button, level, synchronous to clk
lights  output  8  lamp strip, bit0 lit first
lights_out  output  1  one-cycle pulse on the first cycle lamps are off after hold
react_valid  output  1  one-cycle pulse when react_time updates
react_time  output  CNT_W  last reaction time in cycles, held until next start
jump_start  output  1  level, set on early press, cleared on next start
busy  output  1  high in LIGHTS, HOLD, GO

Behaviour:
- Reset is asynchronous on rst_n low. State=IDLE, lights=0, lights_out=0, react_valid=0, react_time=0, jump_start=0, LFSR=7'h01, prescaler=0, trig_q=0.
- Start event: trigger=1 and trig_q=0, with trig_q the registered trigger. Start events are honoured only in IDLE and FAULT and ignored elsewhere.
- Prescaler counts 0..TICK_DIV-1 and is cleared on a start event. tick=1 when prescaler==TICK_DIV-1.
- LFSR is 7-bit Fibonacci, x^7+x^6+1: next={q[5:0], q[6]^q[5]}. It advances exactly once per start event, so races are deterministic after reset. It never reaches 0.
- State IDLE: lights=0. On start: LIGHTS, lights=0, jump_start=0, advance LFSR.
- State LIGHTS: on tick, lights<={lights[6:0],1'b1}. On the tick where lights becomes 8'hFF: HOLD, delay<=LFSR value (1..127).
- State HOLD: lights=8'hFF. On tick, delay decrements. On the tick with delay==1: GO, lights<=0, count<=0.
- State GO: lights=0.
  - lights_out=1 in the first GO cycle only.
  - count increments each cycle and saturates at all-ones.
  - When react=1: react_time<=count, react_valid pulses next cycle, state goes to IDLE.
  - react in the first GO cycle gives react_time=0.
- Jump start: react=1 in any LIGHTS or HOLD cycle gives FAULT, jump_start<=1, lights<=0. This takes priority over a same-cycle tick.
- State FAULT: lights=0 and jump_start stays high. A start event behaves as in IDLE.
- react in IDLE or FAULT is ignored. trigger held high does not restart; only a new rising edge does.
- rst_n low mid-race aborts at once to reset values. No lights_out or react_valid is emitted.
- Output latencies:
  - lights changes the cycle after a tick.
  - lights_out and react_valid are registered, one cycle wide.
  - busy is combinational from state.

Decomposition:
- Package f1_pkg:
  - state enum {IDLE, LIGHTS, HOLD, GO, FAULT}
  - LFSR_SEED=7'h01
  - LFSR width constant 7
  - lamp count 8
- Sub-module f1_lfsr7 (clk, rst_n, step, q[6:0]), reusable by other labs.
- Prescaler, FSM and counter stay inline.

Test Plan:
- Reset, then trigger rise with TICK_DIV=4:
  - lights steps 01,03,07,0F,1F,3F,7F,FF, one step per 4 cycles.
  - HOLD delay is 2 ticks, i.e. 8 cycles of FF.
  - lights_out pulses once, then lights=00, busy=1.
- Same race, react asserted 10 cycles after lights_out:
  - react_valid pulses once with react_time=10.
  - state returns to IDLE, busy=0.
- Second race after race 1 without reset: HOLD lasts 4 ticks (LFSR=0x04), i.e. 16 cycles.
- react asserted while lights=0x07:
  - FAULT, jump_start=1, lights=00, no lights_out.
  - A new trigger edge clears jump_start and restarts from 0x01.
- Trigger held high through a whole race, plus a trigger pulse mid-LIGHTS: no restart, and the sequence timing is unchanged.
- rst_n pulsed low during HOLD:
  - all outputs are zero immediately (asynchronously).
  - After release, the next race uses delay 2 (LFSR re-seeded).
  - With react never pressed and CNT_W=4, react_time saturates at 15.

Source files
------------

// File: rtl/f1_pkg.sv
// rtl/f1_pkg.sv - shared constants for the F1 start-light sequencer
package f1_pkg;

    localparam int          LFSR_W    = 7;
    localparam logic [6:0]  LFSR_SEED = 7'h01;
    localparam int          N_LAMPS   = 8;

    localparam logic [2:0]  ST_IDLE   = 3'd0;
    localparam logic [2:0]  ST_LIGHTS = 3'd1;
    localparam logic [2:0]  ST_HOLD   = 3'd2;
    localparam logic [2:0]  ST_GO     = 3'd3;
    localparam logic [2:0]  ST_FAULT  = 3'd4;

endpackage

// File: rtl/f1_lfsr7.sv
// rtl/f1_lfsr7.sv - 7-bit Fibonacci LFSR (x^7+x^6+1), advances only on step
import f1_pkg::*;

module f1_lfsr7 (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    // Nonzero seed keeps the sequence off the all-zero lock-up state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= LFSR_SEED;
        end else if (step) begin
            q <= {q[5:0], q[6] ^ q[5]};
        end
    end

endmodule

// File: rtl/f1_start_ctrl.sv
// rtl/f1_start_ctrl.sv - race-start light sequencer with reaction timer
import f1_pkg::*;

module f1_start_ctrl #(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               trigger,
    input  logic               react,
    output logic [N_LAMPS-1:0] lights,
    output logic               lights_out,
    output logic               react_valid,
    output logic [CNT_W-1:0]   react_time,
    output logic               jump_start,
    output logic               busy
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [2:0]        state;
    logic              trig_q;
    logic [PW-1:0]     presc;
    logic              tick;
    logic              go_start;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] delay;
    logic [CNT_W-1:0]  count;

    assign tick     = (presc == PW'(TICK_DIV - 1));
    // Edges arriving mid-race are dropped entirely, including the prescaler clear.
    assign go_start = trigger && !trig_q && (state == ST_IDLE || state == ST_FAULT);
    assign busy     = (state == ST_LIGHTS) || (state == ST_HOLD) || (state == ST_GO);

    f1_lfsr7 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (go_start),
        .q     (lfsr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (go_start || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            trig_q      <= 1'b0;
            lights      <= '0;
            lights_out  <= 1'b0;
            react_valid <= 1'b0;
            react_time  <= '0;
            jump_start  <= 1'b0;
            delay       <= '0;
            count       <= '0;
        end else begin
            trig_q      <= trigger;
            lights_out  <= 1'b0;
            react_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_FAULT: begin
                    if (go_start) begin
                        state      <= ST_LIGHTS;
                        lights     <= '0;
                        jump_start <= 1'b0;
                    end
                end
                ST_LIGHTS: begin
                    if (react) begin
                        state      <= ST_FAULT;
                        jump_start <= 1'b1;
                        lights     <= '0;
                    end else if (tick) begin
                        lights <= {lights[N_LAMPS-2:0], 1'b1};
                        if (lights[N_LAMPS-2]) begin
                            state <= ST_HOLD;
                            delay <= lfsr_q;
                        end
                    end
                end
                ST_HOLD: begin
                    if (react) begin
                        state      <= ST_FAULT;
                        jump_start <= 1'b1;
                        lights     <= '0;
                    end else if (tick) begin
                        if (delay == LFSR_W'(1)) begin
                            state      <= ST_GO;
                            lights     <= '0;
                            count      <= '0;
                            lights_out <= 1'b1;
                        end else begin
                            delay <= delay - 1'b1;
                        end
                    end
                end
                ST_GO: begin
                    if (count != '1) begin
                        count <= count + 1'b1;
                    end
                    if (react) begin
                        react_time  <= count;
                        react_valid <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    lights <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f1_start_ctrl.sv
// tb/tb_f1_start_ctrl.sv - self-checking bench for f1_start_ctrl
module tb_f1_start_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trigger, react;
    logic [7:0]  lights;
    logic        lights_out, react_valid, jump_start, busy;
    logic [15:0] react_time;

    logic        trig2, react2;
    logic [7:0]  s_lights;
    logic        s_lights_out, s_react_valid, s_jump_start, s_busy;
    logic [3:0]  s_react_time;

    int checks = 0;
    int errors = 0;
    int lo_cnt = 0;
    int exp_q[$];

    typedef struct {
        int         k;
        logic [7:0] lights;
        logic       lo;
        logic       busy;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    f1_start_ctrl #(.TICK_DIV(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .react(react),
        .lights(lights), .lights_out(lights_out), .react_valid(react_valid),
        .react_time(react_time), .jump_start(jump_start), .busy(busy)
    );

    f1_start_ctrl #(.TICK_DIV(4), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .trigger(trig2), .react(react2),
        .lights(s_lights), .lights_out(s_lights_out), .react_valid(s_react_valid),
        .react_time(s_react_time), .jump_start(s_jump_start), .busy(s_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic trig_edge();
        trigger = 1'b0;
        step(1);
        trigger = 1'b1;
        step(1);
    endtask

    task automatic wait_lights(input logic [7:0] v, input string name);
        for (int i = 0; i < 2000 && lights !== v; i++) @(negedge clk);
        chk(name, lights, v);
    endtask

    task automatic hold_len(input int exp, input string name);
        int n;
        n = 0;
        wait_lights(8'hFF, {name, "_reach_ff"});
        while (lights === 8'hFF && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk(name, n, exp);
        chk({name, "_lights_out"}, lights_out, 1'b1);
    endtask

    task automatic press_after(input int d);
        step(d);
        react = 1'b1;
        exp_q.push_back(d);
        step(1);
        react = 1'b0;
        chk("busy_after_react", busy, 1'b0);
    endtask

    always @(negedge clk) begin
        if (lights_out) lo_cnt++;
        if (rst_n && react_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_react_valid", 1, 0);
            end else begin
                chk("react_time", react_time, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cur, lo0;
        vecs.push_back('{0, 8'h00, 1'b0, 1'b1});
        for (int i = 1; i <= 8; i++) begin
            vecs.push_back('{4*i-1, 8'((1 << (i-1)) - 1), 1'b0, 1'b1});
            vecs.push_back('{4*i,   8'((1 << i) - 1),     1'b0, 1'b1});
        end
        vecs.push_back('{39, 8'hFF, 1'b0, 1'b1});
        vecs.push_back('{40, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{41, 8'h00, 1'b0, 1'b1});

        rst_n = 1'b0; trigger = 1'b0; react = 1'b0; trig2 = 1'b0; react2 = 1'b0;
        step(3);
        chk("rst_lights", lights, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_react_time", react_time, 0);
        chk("rst_jump", jump_start, 1'b0);
        rst_n = 1'b1;
        step(1);

        // race 1: table-driven timing, hold of 2 ticks
        trigger = 1'b1;
        step(1);
        cur = 0;
        foreach (vecs[j]) begin
            while (cur < vecs[j].k) begin step(1); cur++; end
            chk($sformatf("r1_lights_k%0d", vecs[j].k), lights, vecs[j].lights);
            chk($sformatf("r1_lo_k%0d", vecs[j].k), lights_out, vecs[j].lo);
            chk($sformatf("r1_busy_k%0d", vecs[j].k), busy, vecs[j].busy);
        end
        step(50 - cur);
        react = 1'b1;
        exp_q.push_back(10);
        step(1);
        react = 1'b0;
        chk("r1_busy_idle", busy, 1'b0);
        chk("r1_lo_count", lo_cnt, 1);

        // race 2: LFSR advanced to 0x04, react in first GO cycle
        trig_edge();
        hold_len(16, "r2_hold");
        press_after(0);

        // race 3: jump start at 0x07
        trig_edge();
        wait_lights(8'h07, "r3_reach_07");
        react = 1'b1;
        step(1);
        chk("r3_jump", jump_start, 1'b1);
        chk("r3_lights", lights, 8'h00);
        chk("r3_busy", busy, 1'b0);
        lo0 = lo_cnt;
        step(5);
        react = 1'b0;
        step(40);
        chk("r3_no_lo", lo_cnt, lo0);
        chk("r3_jump_held", jump_start, 1'b1);
        trig_edge();
        chk("r3b_jump_clr", jump_start, 1'b0);
        chk("r3b_busy", busy, 1'b1);
        step(4);
        chk("r3b_lights_01", lights, 8'h01);
        hold_len(64, "r3b_hold");
        press_after(5);

        // race 4: trigger held high, extra edge mid-LIGHTS
        trig_edge();
        step(10);
        trigger = 1'b0;
        step(2);
        trigger = 1'b1;
        step(4);
        chk("r4_lights_0f", lights, 8'h0F);
        step(16);
        chk("r4_lights_ff", lights, 8'hFF);
        hold_len(128, "r4_hold");
        press_after(2);
        step(20);
        chk("r4_no_restart", busy, 1'b0);

        // race 5: async reset during HOLD, then reseeded race
        trig_edge();
        wait_lights(8'hFF, "r5_reach_ff");
        step(3);
        #2 rst_n = 1'b0;
        trigger = 1'b0;
        #1;
        chk("r5_rst_lights", lights, 8'h00);
        chk("r5_rst_busy", busy, 1'b0);
        chk("r5_rst_react_time", react_time, 0);
        chk("r5_rst_lo", lights_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        trig_edge();
        hold_len(8, "r6_hold");
        press_after(3);

        // saturating counter on CNT_W=4 instance
        trig2 = 1'b1;
        for (int i = 0; i < 500 && !s_lights_out; i++) @(negedge clk);
        chk("sat_lights_out", s_lights_out, 1'b1);
        step(30);
        react2 = 1'b1;
        step(1);
        react2 = 1'b0;
        chk("sat_valid", s_react_valid, 1'b1);
        chk("sat_time", s_react_time, 4'd15);

        step(3);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
